// File: rtl/pe_seq_ctrl_if.sv
// Job, loader-handshake and PE-side address bundle for pe_seq_ctrl.
// master: the sequencer; slave: the job issuer / loader / PE datapath side.
interface pe_seq_ctrl_if #(
  parameter int ACTV_ADDR_BITWIDTH = 2,
  parameter int WGT_ADDR_BITWIDTH  = 2,
  parameter int PSUM_ADDR_BITWIDTH = 2,
  parameter int TILE_BITWIDTH      = 8
) ();
  logic                          start;
  logic [PSUM_ADDR_BITWIDTH:0]   cfg_o_len;
  logic [WGT_ADDR_BITWIDTH:0]    cfg_k_len;
  logic [TILE_BITWIDTH-1:0]      cfg_tiles;
  logic                          fill_valid;
  logic                          fill_ack;
  logic                          bank_sel;
  logic                          MAC_en;
  logic [ACTV_ADDR_BITWIDTH-1:0] actv_r_addr;
  logic [WGT_ADDR_BITWIDTH-1:0]  wgt_r_addr;
  logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr;
  logic [PSUM_ADDR_BITWIDTH-1:0] psum_write_addr;
  logic                          psum_en;
  logic                          busy;
  logic                          done;

  modport master (
    input  start, cfg_o_len, cfg_k_len, cfg_tiles, fill_valid,
    output fill_ack, bank_sel, MAC_en, actv_r_addr, wgt_r_addr,
           psum_addr, psum_write_addr, psum_en, busy, done
  );

  modport slave (
    output start, cfg_o_len, cfg_k_len, cfg_tiles, fill_valid,
    input  fill_ack, bank_sel, MAC_en, actv_r_addr, wgt_r_addr,
           psum_addr, psum_write_addr, psum_en, busy, done
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Loop-nest sequencer for one PE_new: drives RF addresses, MAC_en and bank ping-pong.
// Optional PE_CTRL_PERF_CNT_EN adds the 16-bit PERF_stall_cnt output.
module pe_seq_ctrl #(
  parameter int ACTV_ADDR_BITWIDTH = 2,
  parameter int WGT_ADDR_BITWIDTH  = 2,
  parameter int PSUM_ADDR_BITWIDTH = 2,
  parameter int TILE_BITWIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PE_CTRL_PERF_CNT_EN
  output logic [15:0] PERF_stall_cnt,
`endif
  pe_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, WAIT_FILL, RUN, BUBBLE, DRAIN} state_t;

  localparam logic [PSUM_ADDR_BITWIDTH-1:0] O_INC     = 1;
  localparam logic [WGT_ADDR_BITWIDTH-1:0]  I_INC     = 1;
  localparam logic [TILE_BITWIDTH-1:0]      T_INC     = 1;
  localparam logic [PSUM_ADDR_BITWIDTH:0]   O_LEN_ONE = 1;
  localparam logic [WGT_ADDR_BITWIDTH:0]    K_LEN_ONE = 1;

  state_t                        state_q;
  logic [PSUM_ADDR_BITWIDTH-1:0] o_q, o_max_q, adv_o;
  logic [WGT_ADDR_BITWIDTH-1:0]  i_q, k_max_q, adv_i;
  logic [TILE_BITWIDTH-1:0]      tile_q, t_max_q;
  logic                          single_o_q;
  logic                          last_o, last_i, last_tile, tile_end, step;

  logic                          fill_ack_q, bank_sel_q, mac_en_q, psum_en_q, done_q;
  logic [ACTV_ADDR_BITWIDTH-1:0] actv_addr_q;
  logic [WGT_ADDR_BITWIDTH-1:0]  wgt_addr_q;
  logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr_q;

  function automatic logic [ACTV_ADDR_BITWIDTH-1:0] actv_addr(
    input logic [PSUM_ADDR_BITWIDTH-1:0] o,
    input logic [WGT_ADDR_BITWIDTH-1:0]  i
  );
    return ACTV_ADDR_BITWIDTH'(o) + ACTV_ADDR_BITWIDTH'(i);
  endfunction

  // o is the inner loop so back-to-back MACs never hit the same psum entry
  always_comb begin
    last_o    = (o_q == o_max_q);
    last_i    = (i_q == k_max_q);
    last_tile = (tile_q == t_max_q);
    tile_end  = last_o && last_i;
    adv_o     = '0;
    adv_i     = '0;
    if (!last_o) begin
      adv_o = o_q + O_INC;
      adv_i = i_q;
    end else if (!last_i) begin
      adv_i = i_q + I_INC;
    end
    // With a single output the advance is deferred to the BUBBLE cycle
    step = ((state_q == RUN) && !single_o_q) || (state_q == BUBBLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      o_q         <= '0;
      i_q         <= '0;
      tile_q      <= '0;
      o_max_q     <= '0;
      k_max_q     <= '0;
      t_max_q     <= '0;
      single_o_q  <= 1'b0;
      fill_ack_q  <= 1'b0;
      bank_sel_q  <= 1'b1;
      mac_en_q    <= 1'b0;
      psum_en_q   <= 1'b1;
      done_q      <= 1'b0;
      actv_addr_q <= '0;
      wgt_addr_q  <= '0;
      psum_addr_q <= '0;
    end else begin
      fill_ack_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            o_max_q    <= PSUM_ADDR_BITWIDTH'(bus.cfg_o_len - O_LEN_ONE);
            k_max_q    <= WGT_ADDR_BITWIDTH'(bus.cfg_k_len - K_LEN_ONE);
            t_max_q    <= (bus.cfg_tiles == '0) ? '0 : bus.cfg_tiles - T_INC;
            single_o_q <= (bus.cfg_o_len == O_LEN_ONE);
            o_q        <= '0;
            i_q        <= '0;
            tile_q     <= '0;
            if ((bus.cfg_o_len == '0) || (bus.cfg_k_len == '0)) begin
              state_q <= DRAIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_FILL;
            end
          end
        end
        WAIT_FILL: begin
          if (bus.fill_valid) begin
            fill_ack_q  <= 1'b1;
            bank_sel_q  <= ~bank_sel_q;
            state_q     <= RUN;
            mac_en_q    <= 1'b1;
            actv_addr_q <= actv_addr(o_q, i_q);
            wgt_addr_q  <= i_q;
            psum_addr_q <= o_q;
          end
        end
        RUN: begin
          if (single_o_q) begin
            state_q  <= BUBBLE;
            mac_en_q <= 1'b0;
          end
        end
        BUBBLE: ;
        DRAIN: begin
          state_q   <= IDLE;
          psum_en_q <= ~psum_en_q;
        end
        default: state_q <= IDLE;
      endcase

      if (step) begin
        if (!tile_end || !last_tile) begin
          o_q         <= adv_o;
          i_q         <= adv_i;
          actv_addr_q <= actv_addr(adv_o, adv_i);
          wgt_addr_q  <= adv_i;
          psum_addr_q <= adv_o;
        end
        if (!tile_end) begin
          state_q  <= RUN;
          mac_en_q <= 1'b1;
        end else if (!last_tile) begin
          // Next tile: swap banks in the same cycle when the loader is ready
          tile_q <= tile_q + T_INC;
          if (bus.fill_valid) begin
            fill_ack_q <= 1'b1;
            bank_sel_q <= ~bank_sel_q;
            state_q    <= RUN;
            mac_en_q   <= 1'b1;
          end else begin
            state_q  <= WAIT_FILL;
            mac_en_q <= 1'b0;
          end
        end else begin
          state_q  <= DRAIN;
          mac_en_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

`ifdef PE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PERF_stall_cnt <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      PERF_stall_cnt <= '0;
    end else if ((state_q != IDLE) && !mac_en_q && (PERF_stall_cnt != '1)) begin
      PERF_stall_cnt <= PERF_stall_cnt + 16'd1;
    end
  end
`endif

  assign bus.fill_ack        = fill_ack_q;
  assign bus.bank_sel        = bank_sel_q;
  assign bus.MAC_en          = mac_en_q;
  assign bus.actv_r_addr     = actv_addr_q;
  assign bus.wgt_r_addr      = wgt_addr_q;
  assign bus.psum_addr       = psum_addr_q;
  assign bus.psum_write_addr = psum_addr_q;
  assign bus.psum_en         = psum_en_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = done_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed self-checking bench for pe_seq_ctrl (default parameters).
module tb_pe_seq_ctrl;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic exp_bank;
  logic exp_psum;
`ifdef PE_CTRL_PERF_CNT_EN
  logic [15:0] perf;
`endif

  pe_seq_ctrl_if bus ();

  pe_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
`ifdef PE_CTRL_PERF_CNT_EN
    .PERF_stall_cnt (perf),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge; returns in the first cycle after the accept edge
  task automatic start_job(input int o, input int k, input int t);
    bus.cfg_o_len = 3'(o);
    bus.cfg_k_len = 3'(k);
    bus.cfg_tiles = 8'(t);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.cfg_o_len = '0; bus.cfg_k_len = '0; bus.cfg_tiles = '0;
    bus.fill_valid = 1'b0;
    tick(); tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.MAC_en !== 1'b0 || bus.fill_ack !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b MAC_en=%b fill_ack=%b done=%b, required 0000",
               bus.busy, bus.MAC_en, bus.fill_ack, bus.done);
    end
    n_tests++;
    if (bus.bank_sel !== 1'b1 || bus.psum_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_banks: bank_sel=%b psum_en=%b, required 1 1", bus.bank_sel, bus.psum_en);
    end
    n_tests++;
    if (bus.actv_r_addr !== 2'd0 || bus.wgt_r_addr !== 2'd0 || bus.psum_addr !== 2'd0 ||
        bus.psum_write_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_addr: actv=%0d wgt=%0d psum=%0d psum_w=%0d, required all 0",
               bus.actv_r_addr, bus.wgt_r_addr, bus.psum_addr, bus.psum_write_addr);
    end
`ifdef PE_CTRL_PERF_CNT_EN
    n_tests++;
    if (perf !== 16'd0) begin n_fail++; $display("FAIL reset_perf: got %0d, required 0", perf); end
`endif
    reset = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b, required 0", bus.busy); end
    exp_bank = 1'b1;
    exp_psum = 1'b1;
  endtask

  task automatic test_basic_nest();
    int exp_actv [8] = '{0, 1, 2, 3, 1, 2, 3, 0};
    int acks = 0, dones = 0, done_at = 0;
    bus.fill_valid = 1'b1;
    start_job(4, 2, 1);
    for (int c = 1; c <= 11; c++) begin
      if (c >= 2 && c <= 9) begin
        n_tests++;
        if (bus.MAC_en !== 1'b1 || bus.actv_r_addr !== 2'(exp_actv[c-2]) ||
            bus.wgt_r_addr !== 2'((c-2)/4) || bus.psum_write_addr !== 2'((c-2)%4) ||
            bus.psum_addr !== 2'((c-2)%4)) begin
          n_fail++;
          $display("FAIL basic_mac c%0d: MAC_en=%b actv=%0d wgt=%0d psum=%0d psum_w=%0d, required 1/%0d/%0d/%0d/%0d",
                   c, bus.MAC_en, bus.actv_r_addr, bus.wgt_r_addr, bus.psum_addr, bus.psum_write_addr,
                   exp_actv[c-2], (c-2)/4, (c-2)%4, (c-2)%4);
        end
      end else if (c <= 10) begin
        n_tests++;
        if (bus.MAC_en !== 1'b0 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_stall c%0d: MAC_en=%b busy=%b, required 0 1", c, bus.MAC_en, bus.busy);
        end
      end
      if (bus.fill_ack === 1'b1) acks++;
      if (bus.done === 1'b1) begin dones++; if (done_at == 0) done_at = c; end
      tick();
    end
    exp_bank = ~exp_bank;
    exp_psum = ~exp_psum;
    n_tests++;
    if (done_at != 10 || dones != 1) begin
      n_fail++; $display("FAIL basic_done: at c%0d count %0d, required c10 count 1", done_at, dones);
    end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL basic_acks: got %0d, required 1", acks); end
    n_tests++;
    if (bus.psum_en !== exp_psum || bus.bank_sel !== exp_bank || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: psum_en=%b bank_sel=%b busy=%b, required %b %b 0",
               bus.psum_en, bus.bank_sel, bus.busy, exp_psum, exp_bank);
    end
`ifdef PE_CTRL_PERF_CNT_EN
    n_tests++;
    if (perf !== 16'd2) begin n_fail++; $display("FAIL basic_perf: got %0d, required 2", perf); end
`endif
  endtask

  task automatic test_bubble();
    int dones = 0, done_at = 0;
    logic exp_mac;
    start_job(1, 3, 1);
    for (int c = 1; c <= 9; c++) begin
      if (c >= 2 && c <= 7) begin
        exp_mac = (c % 2 == 0);
        n_tests++;
        if (bus.MAC_en !== exp_mac || bus.wgt_r_addr !== 2'((c-2)/2) ||
            bus.actv_r_addr !== 2'((c-2)/2) || bus.psum_write_addr !== 2'd0) begin
          n_fail++;
          $display("FAIL bubble c%0d: MAC_en=%b wgt=%0d actv=%0d psum_w=%0d, required %b/%0d/%0d/0",
                   c, bus.MAC_en, bus.wgt_r_addr, bus.actv_r_addr, bus.psum_write_addr,
                   exp_mac, (c-2)/2, (c-2)/2);
        end
      end
      if (bus.done === 1'b1) begin dones++; if (done_at == 0) done_at = c; end
      tick();
    end
    exp_bank = ~exp_bank;
    exp_psum = ~exp_psum;
    n_tests++;
    if (done_at != 8 || dones != 1) begin
      n_fail++; $display("FAIL bubble_done: at c%0d count %0d, required c8 count 1", done_at, dones);
    end
    n_tests++;
    if (bus.psum_en !== exp_psum || bus.bank_sel !== exp_bank) begin
      n_fail++; $display("FAIL bubble_end: psum_en=%b bank_sel=%b, required %b %b",
                         bus.psum_en, bus.bank_sel, exp_psum, exp_bank);
    end
`ifdef PE_CTRL_PERF_CNT_EN
    n_tests++;
    if (perf !== 16'd5) begin n_fail++; $display("FAIL bubble_perf: got %0d, required 5", perf); end
`endif
  endtask

  task automatic test_back_pressure();
    int   acks = 0, dones = 0, done_at = 0, waits = 0;
    logic ack_bank [3];
    logic exp_mac;
    bus.fill_valid = 1'b1;
    start_job(2, 1, 3);
    for (int c = 1; c <= 14; c++) begin
      exp_mac = (c == 2 || c == 3 || (c >= 9 && c <= 12));
      n_tests++;
      if (bus.MAC_en !== exp_mac) begin
        n_fail++; $display("FAIL bp_mac c%0d: MAC_en=%b, required %b", c, bus.MAC_en, exp_mac);
      end
      if (bus.busy === 1'b1 && bus.MAC_en === 1'b0 && bus.done === 1'b0) waits++;
      if (bus.fill_ack === 1'b1) begin
        if (acks < 3) ack_bank[acks] = bus.bank_sel;
        acks++;
      end
      if (c == 11) begin
        n_tests++;
        if (bus.fill_ack !== 1'b1 || bus.actv_r_addr !== 2'd0 || bus.psum_write_addr !== 2'd0) begin
          n_fail++; $display("FAIL bp_swap: fill_ack=%b actv=%0d psum_w=%0d, required 1 0 0",
                             bus.fill_ack, bus.actv_r_addr, bus.psum_write_addr);
        end
      end
      if (bus.done === 1'b1) begin dones++; if (done_at == 0) done_at = c; end
      bus.fill_valid = !(c >= 2 && c <= 7);
      tick();
    end
    bus.fill_valid = 1'b1;
    n_tests++;
    if (acks != 3) begin n_fail++; $display("FAIL bp_acks: got %0d, required 3", acks); end
    else begin
      n_tests++;
      if (ack_bank[0] !== ~exp_bank || ack_bank[1] !== exp_bank || ack_bank[2] !== ~exp_bank) begin
        n_fail++; $display("FAIL bp_banks: got %b%b%b, required %b%b%b", ack_bank[0], ack_bank[1],
                           ack_bank[2], ~exp_bank, exp_bank, ~exp_bank);
      end
    end
    exp_bank = ~exp_bank;
    exp_psum = ~exp_psum;
    n_tests++;
    if (waits != 6) begin n_fail++; $display("FAIL bp_waits: got %0d, required 6 (1 + 5)", waits); end
    n_tests++;
    if (done_at != 13 || dones != 1) begin
      n_fail++; $display("FAIL bp_done: at c%0d count %0d, required c13 count 1", done_at, dones);
    end
`ifdef PE_CTRL_PERF_CNT_EN
    n_tests++;
    if (perf !== 16'd7) begin n_fail++; $display("FAIL bp_perf: got %0d, required 7", perf); end
`endif
  endtask

  task automatic test_zero_len();
    int ol [2] = '{3, 0};
    int kl [2] = '{0, 2};
    for (int j = 0; j < 2; j++) begin
      start_job(ol[j], kl[j], 1);
      n_tests++;
      if (bus.done !== 1'b1 || bus.MAC_en !== 1'b0 || bus.fill_ack !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL zero_c1 o%0d k%0d: done=%b MAC_en=%b fill_ack=%b busy=%b, required 1 0 0 1",
                           ol[j], kl[j], bus.done, bus.MAC_en, bus.fill_ack, bus.busy);
      end
      tick();
      exp_psum = ~exp_psum;
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.psum_en !== exp_psum || bus.bank_sel !== exp_bank) begin
        n_fail++; $display("FAIL zero_c2 o%0d k%0d: done=%b busy=%b psum_en=%b bank_sel=%b, required 0 0 %b %b",
                           ol[j], kl[j], bus.done, bus.busy, bus.psum_en, bus.bank_sel, exp_psum, exp_bank);
      end
`ifdef PE_CTRL_PERF_CNT_EN
      n_tests++;
      if (perf !== 16'd1) begin n_fail++; $display("FAIL zero_perf: got %0d, required 1", perf); end
`endif
    end
  endtask

  task automatic test_reset_mid_run();
    int acks = 0, dones = 0, done_at = 0, macs = 0;
    int exp_actv [4] = '{0, 1, 1, 2};
    start_job(4, 2, 1);
    tick(); tick(); tick();
    n_tests++;
    if (bus.MAC_en !== 1'b1 || bus.actv_r_addr !== 2'd2) begin
      n_fail++; $display("FAIL rst_pre: MAC_en=%b actv=%0d, required 1 2", bus.MAC_en, bus.actv_r_addr);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.MAC_en !== 1'b0 || bus.bank_sel !== 1'b1 || bus.psum_en !== 1'b1 ||
        bus.actv_r_addr !== 2'd0 || bus.wgt_r_addr !== 2'd0 || bus.psum_write_addr !== 2'd0 ||
        bus.done !== 1'b0 || bus.fill_ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: busy=%b MAC_en=%b bank_sel=%b psum_en=%b actv=%0d wgt=%0d psum_w=%0d done=%b ack=%b, required 0 0 1 1 0 0 0 0 0",
                         bus.busy, bus.MAC_en, bus.bank_sel, bus.psum_en, bus.actv_r_addr,
                         bus.wgt_r_addr, bus.psum_write_addr, bus.done, bus.fill_ack);
    end
    tick();
    reset = 1'b0;
    exp_bank = 1'b1;
    exp_psum = 1'b1;
    tick();
    start_job(2, 2, 0);
    for (int c = 1; c <= 7; c++) begin
      if (c >= 2 && c <= 5) begin
        n_tests++;
        if (bus.MAC_en !== 1'b1 || bus.actv_r_addr !== 2'(exp_actv[c-2])) begin
          n_fail++; $display("FAIL rst_job c%0d: MAC_en=%b actv=%0d, required 1 %0d",
                             c, bus.MAC_en, bus.actv_r_addr, exp_actv[c-2]);
        end
      end
      if (bus.MAC_en === 1'b1) macs++;
      if (bus.fill_ack === 1'b1) acks++;
      if (bus.done === 1'b1) begin dones++; if (done_at == 0) done_at = c; end
      tick();
    end
    exp_bank = ~exp_bank;
    exp_psum = ~exp_psum;
    n_tests++;
    if (macs != 4 || acks != 1 || dones != 1 || done_at != 6) begin
      n_fail++; $display("FAIL rst_job_totals: macs=%0d acks=%0d dones=%0d done_at=c%0d, required 4 1 1 c6",
                         macs, acks, dones, done_at);
    end
    n_tests++;
    if (bus.bank_sel !== exp_bank || bus.psum_en !== exp_psum) begin
      n_fail++; $display("FAIL rst_job_end: bank_sel=%b psum_en=%b, required %b %b",
                         bus.bank_sel, bus.psum_en, exp_bank, exp_psum);
    end
  endtask

  task automatic test_ignored_start();
    int acks = 0, dones = 0, done_at = 0, macs = 0;
    start_job(2, 2, 2);
    for (int c = 1; c <= 12; c++) begin
      if (bus.MAC_en === 1'b1) macs++;
      if (bus.fill_ack === 1'b1) acks++;
      if (bus.done === 1'b1) begin dones++; if (done_at == 0) done_at = c; end
      if (c == 9) begin
        n_tests++;
        if (bus.wgt_r_addr !== 2'd1 || bus.actv_r_addr !== 2'd2) begin
          n_fail++; $display("FAIL ign_last_mac: wgt=%0d actv=%0d, required 1 2", bus.wgt_r_addr, bus.actv_r_addr);
        end
      end
      if (c >= 11) begin
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle c%0d: busy=%b, required 0", c, bus.busy); end
      end
      bus.start = (c == 3 || c == 10);
      if (c == 3) begin
        bus.cfg_o_len = 3'd1; bus.cfg_k_len = 3'd0; bus.cfg_tiles = 8'd5;
      end
      tick();
    end
    bus.start = 1'b0;
    exp_psum = ~exp_psum;
    n_tests++;
    if (macs != 8 || acks != 2 || dones != 1 || done_at != 10) begin
      n_fail++; $display("FAIL ign_totals: macs=%0d acks=%0d dones=%0d done_at=c%0d, required 8 2 1 c10",
                         macs, acks, dones, done_at);
    end
    n_tests++;
    if (bus.bank_sel !== exp_bank || bus.psum_en !== exp_psum) begin
      n_fail++; $display("FAIL ign_end: bank_sel=%b psum_en=%b, required %b %b",
                         bus.bank_sel, bus.psum_en, exp_bank, exp_psum);
    end
`ifdef PE_CTRL_PERF_CNT_EN
    n_tests++;
    if (perf !== 16'd2) begin n_fail++; $display("FAIL ign_perf: got %0d, required 2", perf); end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_nest();
    test_bubble();
    test_back_pressure();
    test_zero_len();
    test_reset_mid_run();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
